// File: rtl/lsu_addr_demux.sv
// lsu_addr_demux: routes LSU requests to one of NUM_CH address windows (comb or sliced) and returns ack/rdata.
module lsu_addr_demux #(
  parameter int                        NUM_CH  = 2,
  parameter logic [NUM_CH-1:0][31:0]   CH_BASE = {32'h0009_0000, 32'h0001_0000},
  parameter logic [NUM_CH-1:0][31:0]   CH_END  = {32'h0009_ffff, 32'h0001_ffff},
  parameter logic [NUM_CH-1:0]         CH_REG  = 2'b10,
  parameter int                        TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_lsu_req,
  input  logic                  i_lsu_we,
  input  logic [31:0]           i_lsu_addr,
  input  logic [31:0]           i_lsu_wdata,
  input  logic [3:0]            i_lsu_strb,
  input  logic [3:0]            i_lsu_amo,
  input  logic [1:0]            i_lsu_size,
  output logic                  o_lsu_ack,
  output logic                  o_lsu_error,
  output logic [31:0]           o_lsu_rdata,
  output logic [NUM_CH-1:0]     o_ch_req,
  output logic [NUM_CH-1:0]     o_ch_we,
  output logic [32*NUM_CH-1:0]  o_ch_addr,
  output logic [32*NUM_CH-1:0]  o_ch_wdata,
  output logic [4*NUM_CH-1:0]   o_ch_strb,
  output logic [4*NUM_CH-1:0]   o_ch_amo,
  output logic [2*NUM_CH-1:0]   o_ch_size,
  input  logic [NUM_CH-1:0]     i_ch_ack,
  input  logic [32*NUM_CH-1:0]  i_ch_rdata
);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_sel, w_hit_idx, w_cur;
  logic [TW-1:0] r_tmo;
  logic          w_hit, w_decode, w_ok, w_tmo, w_err;
  logic          r_sl_req, r_sl_we;
  logic [31:0]   r_sl_addr, r_sl_wdata;
  logic [3:0]    r_sl_strb, r_sl_amo;
  logic [1:0]    r_sl_size;
  // Descending scan so the lowest matching window wins on overlap.
  always_comb begin
    w_hit = 1'b0;
    w_hit_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (i_lsu_addr >= CH_BASE[k] && i_lsu_addr <= CH_END[k]) begin
        w_hit = 1'b1;
        w_hit_idx = SW'(k);
      end
  end
  assign w_decode = rst_ni && r_state == S_IDLE && i_lsu_req && w_hit;
  assign w_cur    = r_state == S_IDLE ? w_hit_idx : r_sel;
  assign w_ok     = i_ch_ack[w_cur] && (r_state == S_WAIT || (w_decode && !CH_REG[w_cur]));
  assign w_tmo    = TIMEOUT != 0 && r_state == S_WAIT && !w_ok && r_tmo == TW'(TIMEOUT - 1);
  assign w_err    = r_state == S_ERR || w_tmo;
  assign o_lsu_ack   = w_ok || w_err;
  assign o_lsu_error = w_err;
  assign o_lsu_rdata = w_ok ? i_ch_rdata[32*w_cur +: 32] : '0;
  assign w_state_nxt = r_state == S_IDLE ? (!i_lsu_req ? S_IDLE : !w_hit ? S_ERR : w_ok ? S_IDLE : S_WAIT)
                     : r_state == S_WAIT ? ((w_ok || w_tmo) ? S_IDLE : S_WAIT)
                     : S_IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_tmo      <= '0;
      r_sl_req   <= 1'b0;
      r_sl_we    <= 1'b0;
      r_sl_addr  <= '0;
      r_sl_wdata <= '0;
      r_sl_strb  <= '0;
      r_sl_amo   <= '0;
      r_sl_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_decode) r_sel <= w_hit_idx;
      r_tmo <= (r_state != S_WAIT || w_state_nxt != S_WAIT) ? '0 : (&r_tmo ? r_tmo : r_tmo + 1'b1);
      if (w_decode && CH_REG[w_hit_idx]) begin
        r_sl_req   <= 1'b1;
        r_sl_we    <= i_lsu_we;
        r_sl_addr  <= i_lsu_addr;
        r_sl_wdata <= i_lsu_wdata;
        r_sl_strb  <= i_lsu_strb;
        r_sl_amo   <= i_lsu_amo;
        r_sl_size  <= i_lsu_size;
      end else if (r_state == S_WAIT && (w_ok || w_tmo)) begin
        r_sl_req <= 1'b0;
      end
    end
  end
  always_comb begin
    o_ch_req   = '0;
    o_ch_we    = '0;
    o_ch_addr  = '0;
    o_ch_wdata = '0;
    o_ch_strb  = '0;
    o_ch_amo   = '0;
    o_ch_size  = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (!CH_REG[k] && w_cur == SW'(k) && (w_decode || r_state == S_WAIT)) begin
        o_ch_req[k]            = i_lsu_req;
        o_ch_we[k]             = i_lsu_we;
        o_ch_addr[32*k +: 32]  = i_lsu_addr;
        o_ch_wdata[32*k +: 32] = i_lsu_wdata;
        o_ch_strb[4*k +: 4]    = i_lsu_strb;
        o_ch_amo[4*k +: 4]     = i_lsu_amo;
        o_ch_size[2*k +: 2]    = i_lsu_size;
      end else if (CH_REG[k] && r_sl_req && r_sel == SW'(k)) begin
        o_ch_req[k]            = 1'b1;
        o_ch_we[k]             = r_sl_we;
        o_ch_addr[32*k +: 32]  = r_sl_addr;
        o_ch_wdata[32*k +: 32] = r_sl_wdata;
        o_ch_strb[4*k +: 4]    = r_sl_strb;
        o_ch_amo[4*k +: 4]     = r_sl_amo;
        o_ch_size[2*k +: 2]    = r_sl_size;
      end
  end
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni) r_state != S_IDLE |-> i_lsu_req);
endmodule

// File: tb/tb_lsu_addr_demux.sv
// tb_lsu_addr_demux: directed checks of decode, comb/sliced forwarding, errors, timeout and reset.
module tb_lsu_addr_demux;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_strb, lsu_amo;
  logic [1:0]  lsu_size;
  logic        ack, error;
  logic [31:0] rdata;
  logic [1:0]  ch_req, ch_we, ch_ack;
  logic [63:0] ch_addr, ch_wdata, ch_rdata;
  logic [7:0]  ch_strb, ch_amo;
  logic [3:0]  ch_size;
  logic [35:0] obs;
  logic [35:0] exp_v;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign obs = {ack, error, ch_req, rdata};
  lsu_addr_demux #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
    .i_lsu_strb(lsu_strb), .i_lsu_amo(lsu_amo), .i_lsu_size(lsu_size),
    .o_lsu_ack(ack), .o_lsu_error(error), .o_lsu_rdata(rdata),
    .o_ch_req(ch_req), .o_ch_we(ch_we), .o_ch_addr(ch_addr), .o_ch_wdata(ch_wdata),
    .o_ch_strb(ch_strb), .o_ch_amo(ch_amo), .o_ch_size(ch_size),
    .i_ch_ack(ch_ack), .i_ch_rdata(ch_rdata)
  );
  task step;
    @(posedge clk);
    #1;
  endtask
  task drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] wd);
    lsu_req = r; lsu_addr = a; lsu_we = w; lsu_wdata = wd;
    lsu_strb = 4'hf; lsu_amo = 4'h0; lsu_size = 2'd2;
  endtask
  task chan(input logic [1:0] ak, input logic [31:0] rd0, input logic [31:0] rd1);
    ch_ack = ak; ch_rdata = {rd1, rd0};
  endtask
  task test_reset;
    rst_ni = 1'b0;
    drive(1'b1, 32'h0001_0004, 1'b0, 32'h0);
    chan(2'b01, 32'hdead_beef, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", obs); end
    checks++; if (ch_addr !== 64'h0) begin errors++; $display("FAIL reset_ch_addr: got %h exp 0", ch_addr); end
    step;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chan(2'b00, 32'h0, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL reset_release: got %h exp 0", obs); end
  endtask
  task test_comb_ch0;
    step;
    drive(1'b1, 32'h0001_0004, 1'b0, 32'h0);
    chan(2'b01, 32'hdead_beef, 32'h5555_5555);
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b01, 32'hdead_beef};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL comb_ack: got %h exp %h", obs, exp_v); end
    checks++; if (ch_addr !== 64'h0000_0000_0001_0004) begin errors++; $display("FAIL comb_addr: got %h exp 0000000000010004", ch_addr); end
    step;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chan(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL comb_idle: got %h exp 0", obs); end
  endtask
  task test_reg_ch1;
    step;
    drive(1'b1, 32'h0009_0010, 1'b1, 32'h1234_5678);
    chan(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL reg_c0: got %h exp 0", obs); end
    step;
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'b10, 32'h0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reg_c1: got %h exp %h", obs, exp_v); end
    checks++; if (ch_addr !== 64'h0009_0010_0000_0000) begin errors++; $display("FAIL reg_addr: got %h exp 0009001000000000", ch_addr); end
    checks++; if (ch_wdata !== 64'h1234_5678_0000_0000) begin errors++; $display("FAIL reg_wdata: got %h exp 1234567800000000", ch_wdata); end
    checks++; if (ch_we !== 2'b10) begin errors++; $display("FAIL reg_we: got %b exp 10", ch_we); end
    step;
    @(negedge clk);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reg_c2: got %h exp %h", obs, exp_v); end
    step;
    chan(2'b10, 32'h0, 32'h0000_0001);
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b10, 32'h1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reg_c3_ack: got %h exp %h", obs, exp_v); end
    step;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chan(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL reg_c4_clear: got %h exp 0", obs); end
  endtask
  task test_unmapped;
    logic [31:0] addrs [3];
    addrs = '{32'h0005_0000, 32'h0000_ffff, 32'h0002_0000};
    for (int i = 0; i < 3; i++) begin
      step;
      drive(1'b1, addrs[i], 1'b0, 32'h0);
      chan(2'b11, 32'h111, 32'h222);
      @(negedge clk);
      checks++; if (obs !== 36'h0) begin errors++; $display("FAIL unmapped_c0 %h: got %h exp 0", addrs[i], obs); end
      step;
      @(negedge clk);
      exp_v = {1'b1, 1'b1, 2'b00, 32'h0};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL unmapped_c1 %h: got %h exp %h", addrs[i], obs, exp_v); end
      step;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chan(2'b00, 32'h0, 32'h0);
      @(negedge clk);
      checks++; if (obs !== 36'h0) begin errors++; $display("FAIL unmapped_c2 %h: got %h exp 0", addrs[i], obs); end
    end
  endtask
  task test_timeout;
    step;
    drive(1'b1, 32'h0009_ffff, 1'b0, 32'h0);
    chan(2'b01, 32'h77, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL tmo_decode: got %h exp 0", obs); end
    chan(2'b00, 32'h0, 32'h0);
    exp_v = {1'b0, 1'b0, 2'b10, 32'h0};
    for (int i = 1; i < 4; i++) begin
      step;
      @(negedge clk);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL tmo_wait%0d: got %h exp %h", i, obs, exp_v); end
    end
    step;
    @(negedge clk);
    exp_v = {1'b1, 1'b1, 2'b10, 32'h0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL tmo_error: got %h exp %h", obs, exp_v); end
    step;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL tmo_after: got %h exp 0", obs); end
  endtask
  task test_back_to_back;
    step;
    drive(1'b1, 32'h0001_ffff, 1'b0, 32'h0);
    chan(2'b01, 32'ha1, 32'h0);
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b01, 32'ha1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_ch0a: got %h exp %h", obs, exp_v); end
    step;
    drive(1'b1, 32'h0009_0000, 1'b0, 32'h0);
    chan(2'b01, 32'hbad, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL b2b_ch1_decode: got %h exp 0", obs); end
    step;
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'b10, 32'h0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_stray_ack: got %h exp %h", obs, exp_v); end
    step;
    chan(2'b10, 32'hbad, 32'hb2);
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b10, 32'hb2};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_ch1_ack: got %h exp %h", obs, exp_v); end
    step;
    drive(1'b1, 32'h0001_0000, 1'b0, 32'h0);
    chan(2'b01, 32'hc3, 32'h0);
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b01, 32'hc3};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_ch0b: got %h exp %h", obs, exp_v); end
    step;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chan(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL b2b_idle: got %h exp 0", obs); end
  endtask
  task test_reset_in_wait;
    step;
    drive(1'b1, 32'h0009_0020, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL rstw_decode: got %h exp 0", obs); end
    step;
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'b10, 32'h0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rstw_wait: got %h exp %h", obs, exp_v); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL rstw_async: got %h exp 0", obs); end
    step;
    drive(1'b1, 32'h0001_0008, 1'b0, 32'h0);
    chan(2'b01, 32'h5a5a_5a5a, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b01, 32'h5a5a_5a5a};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rstw_next: got %h exp %h", obs, exp_v); end
    step;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chan(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL rstw_idle: got %h exp 0", obs); end
  endtask
  initial begin
    test_reset;
    test_comb_ch0;
    test_reg_ch1;
    test_unmapped;
    test_timeout;
    test_back_to_back;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
